// File: rtl/charlie_matrix.sv
// charlie_matrix: Wishbone-mapped charlieplexed LED matrix scanner.
// Ports: clk/rst (async active-high); wb_cyc_i/wb_stb_i/wb_we_i/wb_adr_i[3:0]/
//   wb_dat_i[7:0] in, wb_dat_o[7:0]/wb_ack_o out; charlie_o/charlie_oe[PINS-1:0]
//   drive the charlieplexed pins (oe=0 means high-Z).
// Map: addr r<PINS = frame row r (PINS-1 bits); addr 15 = status/control.
// Macro CHARLIE_DOUBLEBUF_EN: front/back frame buffers with swap at frame end.
module charlie_matrix #(
    parameter int PINS          = 7,
    parameter int TICKS_PER_ROW = 1024,
    parameter int BLANK_TICKS   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [3:0]      wb_adr_i,
    input  logic [7:0]      wb_dat_i,
    output logic [7:0]      wb_dat_o,
    output logic            wb_ack_o,
    output logic [PINS-1:0] charlie_o,
    output logic [PINS-1:0] charlie_oe
);

    localparam int RW = PINS - 1;
    localparam int TW = $clog2(TICKS_PER_ROW);
`ifdef CHARLIE_DOUBLEBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_ROW - 1);
    localparam logic [3:0]    ROW_LAST  = 4'(PINS - 1);
    localparam logic [3:0]    STAT_ADR  = 4'hF;

    logic [TW-1:0] tick_q, tick_d;
    logic [3:0]    row_q, row_d;
    logic [NB-1:0][PINS-1:0][RW-1:0] fb_q, fb_d;

    logic          ack_q, ack_d;
    logic [7:0]    dat_q, dat_d;
    logic          req_we_q, req_we_d;
    logic [3:0]    req_adr_q, req_adr_d;
    logic [RW-1:0] req_dat_q, req_dat_d;

    logic [PINS-1:0] pin_o_q, pin_o_d;
    logic [PINS-1:0] pin_oe_q, pin_oe_d;

    logic          disp_bank, bus_bank, pending;
    logic          row_end, frame_end;
    logic [RW-1:0] disp_row, bus_row;
    logic [PINS-1:0] below_v, above_v;
    logic          unused_dat;

    // Upper write-data bits beyond the row width are intentionally dropped.
    assign unused_dat = ^wb_dat_i;

`ifdef CHARLIE_DOUBLEBUF_EN
    logic front_q, front_d;
    logic pend_q, pend_d;
    assign disp_bank = front_q;
    assign bus_bank  = ~front_q;
    assign pending   = pend_q;
`else
    assign disp_bank = 1'b0;
    assign bus_bank  = 1'b0;
    assign pending   = 1'b0;
`endif

    // Scan counters
    assign row_end   = (tick_q == TICK_LAST);
    assign frame_end = row_end && (row_q == ROW_LAST);

    always_comb begin
        tick_d = tick_q + 1'b1;
        row_d  = row_q;
        if (row_end) begin
            tick_d = '0;
            row_d  = frame_end ? 4'd0 : row_q + 4'd1;
        end
    end

    // Row selection for display and bus read
    always_comb begin
        disp_row = '0;
        bus_row  = '0;
        for (int r = 0; r < PINS; r++) begin
            if (row_q == 4'(r))
                disp_row = fb_q[disp_bank][r];
            if (wb_adr_i == 4'(r))
                bus_row = fb_q[bus_bank][r];
        end
    end

    // Pins below the driven row use bit p, pins above use bit p-1;
    // the two shifted copies avoid out-of-range bit selects.
    assign below_v = {1'b0, disp_row};
    assign above_v = {disp_row, 1'b0};

    always_comb begin
        pin_o_d  = '0;
        pin_oe_d = '0;
        if (int'(tick_q) >= BLANK_TICKS) begin
            for (int p = 0; p < PINS; p++) begin
                if (row_q == 4'(p)) begin
                    pin_o_d[p]  = 1'b1;
                    pin_oe_d[p] = 1'b1;
                end else if (4'(p) < row_q) begin
                    pin_oe_d[p] = below_v[p];
                end else begin
                    pin_oe_d[p] = above_v[p];
                end
            end
        end
    end

    // Bus: request is latched when acked; the write lands at the end
    // of the ack cycle, so the master may drop strobe during ack.
    always_comb begin
        ack_d     = wb_cyc_i & wb_stb_i & ~ack_q;
        req_we_d  = req_we_q;
        req_adr_d = req_adr_q;
        req_dat_d = req_dat_q;
        dat_d     = '0;
        if (ack_d) begin
            req_we_d  = wb_we_i;
            req_adr_d = wb_adr_i;
            req_dat_d = wb_dat_i[RW-1:0];
            if (!wb_we_i) begin
                if (wb_adr_i == STAT_ADR)
                    dat_d = {4'b0000, row_q[2:0], pending};
                else
                    dat_d = 8'(bus_row);
            end
        end
    end

    // Frame buffers and swap control
    always_comb begin
        fb_d = fb_q;
`ifdef CHARLIE_DOUBLEBUF_EN
        front_d = front_q;
        pend_d  = pend_q;
        if (frame_end && pend_q) begin
            front_d = ~front_q;
            pend_d  = 1'b0;
        end
        // A request landing on the swap cycle survives to the next frame.
        if (ack_q && req_we_q && req_adr_q == STAT_ADR && req_dat_q[0])
            pend_d = 1'b1;
`endif
        if (ack_q && req_we_q) begin
            for (int r = 0; r < PINS; r++) begin
                if (req_adr_q == 4'(r))
                    fb_d[bus_bank][r] = req_dat_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q    <= '0;
            row_q     <= '0;
            fb_q      <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            req_we_q  <= 1'b0;
            req_adr_q <= '0;
            req_dat_q <= '0;
            pin_o_q   <= '0;
            pin_oe_q  <= '0;
`ifdef CHARLIE_DOUBLEBUF_EN
            front_q   <= 1'b0;
            pend_q    <= 1'b0;
`endif
        end else begin
            tick_q    <= tick_d;
            row_q     <= row_d;
            fb_q      <= fb_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            req_we_q  <= req_we_d;
            req_adr_q <= req_adr_d;
            req_dat_q <= req_dat_d;
            pin_o_q   <= pin_o_d;
            pin_oe_q  <= pin_oe_d;
`ifdef CHARLIE_DOUBLEBUF_EN
            front_q   <= front_d;
            pend_q    <= pend_d;
`endif
        end
    end

    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = dat_q;
    assign charlie_o  = pin_o_q;
    assign charlie_oe = pin_oe_q;

endmodule
